// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: arbitrates the instruction-fetch port and the load/store port
// onto a single byte-wide RAM. Each access is serialised into byte beats;
// read bytes are reassembled little-endian and sign/zero extended.
//
// Ports:
//   clock, reset (async, active-low)
//   if_req/if_addr            -> if_done/if_data        fetch port (full width)
//   mem_read/mem_write/mem_addr/mem_len/mem_signed/mem_wdata
//                             -> mem_done/mem_rdata     load/store port
//   busy                      high in RD, WR, DONE
//   ram_rw/ram_addr/ram_w_data/ram_r_data               byte RAM, 1-cycle read
//
// Optional build macro MEM_CTRL_IBUF_EN adds a one-entry fetch buffer
// {valid, address, word}; a hit completes in one cycle without RAM traffic.
//
// state | meaning
// IDLE  | waiting for a request; the only state in which a grant is made
// RD    | read beats, then capture of the last byte
// WR    | write beats, one byte per cycle
// DONE  | one-cycle done pulse on the granted port
module mem_ctrl_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_done,
  output logic [8*DATA_BYTES-1:0] if_data,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [3:0]              mem_len,
  input  logic                    mem_signed,
  input  logic [8*DATA_BYTES-1:0] mem_wdata,
  output logic                    mem_done,
  output logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    busy,
  output logic                    ram_rw,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [7:0]              ram_w_data,
  input  logic [7:0]              ram_r_data
);

  localparam int CW = $clog2(DATA_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]                 cnt, len_q, eff_len, cnt_m1;
  logic [ADDR_WIDTH-1:0]         base_q;
  logic                          sign_q, fetch_q;
  logic [DATA_BYTES-1:0][7:0]    wdata_q, rbuf, rd_word;
  logic                          gnt_wr, gnt_rd, gnt_if, hit, fill, rd_last;

`ifdef MEM_CTRL_IBUF_EN
  logic                          ibuf_valid;
  logic [ADDR_WIDTH-1:0]         ibuf_addr;
  logic [8*DATA_BYTES-1:0]       ibuf_word;
`endif

  // A zero-length mem request is never granted and does not block a fetch.
  assign gnt_wr = mem_write && (mem_len != 4'd0);
  assign gnt_rd = mem_read && !mem_write && (mem_len != 4'd0);
  assign gnt_if = if_req && !gnt_wr && !gnt_rd;

`ifdef MEM_CTRL_IBUF_EN
  assign hit = gnt_if && ibuf_valid && (if_addr == ibuf_addr);
`else
  assign hit = 1'b0;
`endif

  assign eff_len = (mem_len > 4'(DATA_BYTES)) ? CW'(DATA_BYTES) : CW'(mem_len);
  assign cnt_m1  = cnt - CW'(1);
  assign rd_last = (state == RD) && (cnt == len_q);

  // Final read word: earlier bytes from rbuf, last byte straight off the RAM
  // bus in the capture cycle, the rest filled with the extension bit.
  assign fill = sign_q & ram_r_data[7];
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i < int'(len_q) - 1)       rd_word[i] = rbuf[i];
      else if (i == int'(len_q) - 1) rd_word[i] = ram_r_data;
      else                           rd_word[i] = {8{fill}};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ram_rw     = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    case (state)
      IDLE: begin
        if (gnt_wr)      state_nxt = WR;
        else if (gnt_rd) state_nxt = RD;
        else if (hit)    state_nxt = DONE;
        else if (gnt_if) state_nxt = RD;
      end
      RD: begin
        // cnt == len_q is the capture-only cycle; no address is driven.
        if (cnt != len_q) ram_addr = base_q + ADDR_WIDTH'(cnt);
        else              state_nxt = DONE;
      end
      WR: begin
        ram_rw     = 1'b1;
        ram_addr   = base_q + ADDR_WIDTH'(cnt);
        ram_w_data = wdata_q[cnt[CW-2:0]];
        if (cnt == len_q - CW'(1)) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign if_done  = (state == DONE) && fetch_q;
  assign mem_done = (state == DONE) && !fetch_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      sign_q     <= 1'b0;
      fetch_q    <= 1'b0;
      wdata_q    <= '0;
      rbuf       <= '0;
      if_data    <= '0;
      mem_rdata  <= '0;
`ifdef MEM_CTRL_IBUF_EN
      ibuf_valid <= 1'b0;
      ibuf_addr  <= '0;
      ibuf_word  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt_wr || gnt_rd) begin
            base_q  <= mem_addr;
            len_q   <= eff_len;
            sign_q  <= mem_signed;
            wdata_q <= mem_wdata;
            fetch_q <= 1'b0;
          end else if (gnt_if) begin
            base_q  <= if_addr;
            len_q   <= CW'(DATA_BYTES);
            sign_q  <= 1'b0;
            fetch_q <= 1'b1;
          end
`ifdef MEM_CTRL_IBUF_EN
          if (gnt_wr) ibuf_valid <= 1'b0;
          if (hit)    if_data    <= ibuf_word;
`endif
        end
        RD: begin
          cnt <= cnt + CW'(1);
          if (cnt != '0) rbuf[cnt_m1[CW-2:0]] <= ram_r_data;
          if (rd_last) begin
            if (fetch_q) if_data   <= rd_word;
            else         mem_rdata <= rd_word;
`ifdef MEM_CTRL_IBUF_EN
            if (fetch_q) begin
              ibuf_valid <= 1'b1;
              ibuf_addr  <= base_q;
              ibuf_word  <= rd_word;
            end
`endif
          end
        end
        WR: cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
module tb_mem_ctrl_arb;
  localparam int AW = 32;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [31:0]   if_data;
  logic          mem_read, mem_write, mem_signed;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_len;
  logic [31:0]   mem_wdata;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic          busy, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_w_data;
  logic [7:0]    ram_r_data;

  always #5 clock = ~clock;

  mem_ctrl_arb #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_signed(mem_signed), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data)
  );

  // Byte RAM model: 1 KiB aliased over the address space, one-cycle read.
  logic [7:0] ram [0:1023];
  logic       tb_we;
  logic [9:0] tb_wa;
  logic [7:0] tb_wd;
  always @(posedge clock) begin
    if (ram_rw)     ram[ram_addr[9:0]] <= ram_w_data;
    else if (tb_we) ram[tb_wa] <= tb_wd;
    ram_r_data <= ram[ram_addr[9:0]];
  end

  int n_cmp = 0;
  int n_err = 0;

  int          lat;
  logic [31:0] rdata;
  logic [31:0] tr_addr [0:40];
  logic        tr_rw   [0:40];
  logic [7:0]  tr_wd   [0:40];
  logic        tr_busy [0:40];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clock); #1;
    tb_we = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl"}, {59'd0, if_done, mem_done, busy, ram_rw}, 64'd0);
    check({tag, "_bus"}, {24'd0, ram_addr, ram_w_data}, 64'd0);
    check({tag, "_data"}, {if_data, mem_rdata}, 64'd0);
  endtask

  // kind: 0 fetch, 1 load, 2 store. Starts in an IDLE cycle (cycle 0),
  // returns done latency in lat (99 on timeout), then lets DONE->IDLE pass.
  task automatic run_req(input int kind, input logic [31:0] addr, input logic [3:0] len,
                         input logic sgn, input logic [31:0] wd);
    for (int i = 0; i <= 40; i++) begin
      tr_addr[i] = '0; tr_rw[i] = 1'b0; tr_wd[i] = '0; tr_busy[i] = 1'b0;
    end
    if (kind == 0) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_read = (kind == 1); mem_write = (kind == 2);
      mem_addr = addr; mem_len = len; mem_signed = sgn; mem_wdata = wd;
    end
    lat = 99; rdata = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      tr_addr[c] = ram_addr; tr_rw[c] = ram_rw; tr_wd[c] = ram_w_data; tr_busy[c] = busy;
      if ((kind == 0 && if_done) || (kind != 0 && mem_done)) begin
        lat = c;
        rdata = (kind == 0) ? if_data : mem_rdata;
        break;
      end
    end
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clock); #1;
  endtask

  int md_cyc, id_cyc, dn_cnt, bz_cnt;
  logic [31:0] a5;

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_len = '0;
    mem_signed = 1'b0; mem_wdata = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

    repeat (3) @(posedge clock); #1;
    check_zero_outputs("reset");

    poke(10'h100, 8'h11); poke(10'h101, 8'h22); poke(10'h102, 8'h33); poke(10'h103, 8'h44);
    poke(10'h020, 8'h80);
    poke(10'h030, 8'h34); poke(10'h031, 8'h92);
    poke(10'h3FE, 8'hA1); poke(10'h3FF, 8'hB2); poke(10'h000, 8'hC3); poke(10'h001, 8'hD4);
    poke(10'h200, 8'h00); poke(10'h201, 8'h00);
    reset = 1'b1;
    @(posedge clock); #1;

    // Fetch at 0x100
    run_req(0, 32'h100, 4'd0, 1'b0, 32'h0);
    check("fetch_a1", tr_addr[1], 32'h100);
    check("fetch_a2", tr_addr[2], 32'h101);
    check("fetch_a3", tr_addr[3], 32'h102);
    check("fetch_a4", tr_addr[4], 32'h103);
    check("fetch_a5_idle", tr_addr[5], 32'h0);
    check("fetch_rw", {63'd0, tr_rw[1] | tr_rw[2] | tr_rw[3] | tr_rw[4]}, 64'd0);
    check("fetch_busy", {63'd0, tr_busy[1]}, 64'd1);
    check("fetch_lat", lat, 6);
    check("fetch_data", rdata, 32'h44332211);

    // Byte loads, signed and unsigned
    run_req(1, 32'h20, 4'd1, 1'b1, 32'h0);
    check("lb_lat", lat, 3);
    check("lb_signed", rdata, 32'hFFFFFF80);
    run_req(1, 32'h20, 4'd1, 1'b0, 32'h0);
    check("lb_unsigned", rdata, 32'h00000080);
    run_req(1, 32'h30, 4'd2, 1'b1, 32'h0);
    check("lh_lat", lat, 4);
    check("lh_signed", rdata, 32'hFFFF9234);

    // Halfword store at 0x3E
    run_req(2, 32'h3E, 4'd2, 1'b0, 32'hAABBCCDD);
    check("st_lat", lat, 3);
    check("st_rw", {61'd0, tr_rw[1], tr_rw[2], tr_rw[3]}, 64'b110);
    check("st_a1", tr_addr[1], 32'h3E);
    check("st_a2", tr_addr[2], 32'h3F);
    check("st_d1", tr_wd[1], 8'hDD);
    check("st_d2", tr_wd[2], 8'hCC);
    run_req(1, 32'h3E, 4'd2, 1'b0, 32'h0);
    check("st_readback", rdata, 32'h0000CCDD);

    // Address wrap on fetch
    run_req(0, 32'hFFFFFFFE, 4'd0, 1'b0, 32'h0);
    check("wrap_a1", tr_addr[1], 32'hFFFFFFFE);
    check("wrap_a2", tr_addr[2], 32'hFFFFFFFF);
    check("wrap_a3", tr_addr[3], 32'h0);
    check("wrap_a4", tr_addr[4], 32'h1);
    check("wrap_data", rdata, 32'hD4C3B2A1);

    // Length clamp (no fill, sign ignored) and 3-byte signed load across wrap
    run_req(1, 32'h100, 4'd8, 1'b1, 32'h0);
    check("clamp_lat", lat, 6);
    check("clamp_data", rdata, 32'h44332211);
    run_req(1, 32'hFFFFFFFE, 4'd3, 1'b1, 32'h0);
    check("l3_lat", lat, 5);
    check("l3_data", rdata, 32'hFFC3B2A1);

    // Zero-length mem request is never granted
    mem_read = 1'b1; mem_addr = 32'h20; mem_len = 4'd0;
    bz_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      if (busy || mem_done) bz_cnt++;
    end
    mem_read = 1'b0;
    check("len0_no_grant", bz_cnt, 0);

    // Concurrent fetch and load: load first, fetch after DONE
    mem_read = 1'b1; mem_addr = 32'h20; mem_len = 4'd1; mem_signed = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    md_cyc = 0; id_cyc = 0; a5 = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); #1;
      if (mem_done && md_cyc == 0) begin md_cyc = c; mem_read = 1'b0; end
      if (if_done && id_cyc == 0) begin id_cyc = c; if_req = 1'b0; end
      if (c == 5) a5 = ram_addr;
      if (id_cyc != 0) break;
    end
    if_req = 1'b0; mem_read = 1'b0;
    @(posedge clock); #1;
    check("arb_mem_done_cyc", md_cyc, 3);
    check("arb_if_done_cyc", id_cyc, 10);
    check("arb_fetch_a_c5", a5, 32'h100);
    check("arb_mem_data", mem_rdata, 32'h00000080);
    check("arb_if_data", if_data, 32'h44332211);

    // Reset during beat 2 of a 4-byte store
    mem_write = 1'b1; mem_addr = 32'h200; mem_len = 4'd4; mem_wdata = 32'h55667788;
    @(posedge clock); #1;
    check("rst_beat1", {31'd0, ram_rw, ram_addr}, {31'd0, 1'b1, 32'h200});
    @(posedge clock); #1;
    check("rst_beat2", {31'd0, ram_rw, ram_addr}, {31'd0, 1'b1, 32'h201});
    reset = 1'b0; mem_write = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    @(posedge clock); #1;
    reset = 1'b1;
    dn_cnt = 0; bz_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (if_done || mem_done) dn_cnt++;
      if (busy) bz_cnt++;
    end
    check("rst_no_done", dn_cnt, 0);
    check("rst_idle", bz_cnt, 0);
    check("rst_partial_b0", ram[10'h200], 8'h88);
    check("rst_partial_b1", ram[10'h201], 8'h00);

    // Fetch buffer behaviour
    run_req(0, 32'h100, 4'd0, 1'b0, 32'h0);
    check("ib_first_lat", lat, 6);
    run_req(0, 32'h100, 4'd0, 1'b0, 32'h0);
    check("ib_repeat_data", rdata, 32'h44332211);
`ifdef MEM_CTRL_IBUF_EN
    check("ib_repeat_lat", lat, 1);
    check("ib_repeat_noram", tr_addr[1], 32'h0);
`else
    check("ib_repeat_lat", lat, 6);
`endif
    run_req(2, 32'h300, 4'd1, 1'b0, 32'h0000005A);
    check("ib_store_lat", lat, 2);
    run_req(0, 32'h100, 4'd0, 1'b0, 32'h0);
    check("ib_after_store_lat", lat, 6);
    check("ib_after_store_data", rdata, 32'h44332211);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
